// File: rtl/account_arbiter_pkg.sv
// account_arbiter shared definitions.
// Op codes, response codes, FSM states and the reset balance.
package account_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_BAL = 2'd0,
    OP_WD  = 2'd1,
    OP_DEP = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_INSUF   = 2'd1,
    ERR_BAD_ACC = 2'd2,
    ERR_OVF     = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int INIT_BAL_DEF = 500;

endpackage

// File: rtl/account_arbiter_rr.sv
// Round-robin one-hot grant picker.
// Searches from ptr+1 upward, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      for (int j = 0; j < N; j++) begin
        if (j == idx && en && !found && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/account_arbiter.sv
// Shared-balance arbiter: round-robin grant, atomic
// read-modify-write on the balance store, tagged response.
module account_arbiter
  import account_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_ACC = 10,
  parameter int BAL_W   = 32,
  parameter int AMT_W   = 16,
  parameter logic [BAL_W-1:0] INIT_BAL = BAL_W'(INIT_BAL_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [4*NUM_REQ-1:0]     req_acc,
  input  logic [AMT_W*NUM_REQ-1:0] req_amt,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [2:0]               resp_id,
  output logic [1:0]               resp_err,
  output logic [BAL_W-1:0]         resp_balance,
  output logic                     busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e state, state_nxt;
  logic [PW-1:0] rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0] gid;

  op_e op_sel, op_q;
  logic [3:0] acc_sel, acc_q;
  logic [AMT_W-1:0] amt_sel, amt_q;

  logic [BAL_W-1:0] bal [NUM_ACC];
  logic [BAL_W-1:0] rd, res, amt_ext;
  logic [BAL_W:0] sum;
  logic bad, wr_en;
  err_e err_c;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (state == S_IDLE),
    .grant (grant)
  );

  assign req_ready  = grant;
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  always_comb begin
    gid     = '0;
    op_sel  = OP_BAL;
    acc_sel = '0;
    amt_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        gid     = PW'(j);
        op_sel  = op_e'(req_op[2*j +: 2]);
        acc_sel = req_acc[4*j +: 4];
        amt_sel = req_amt[AMT_W*j +: AMT_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (|req_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single read port; out-of-range index reads as zero
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (acc_q == 4'(i)) rd = bal[i];
    end
  end

  assign bad     = int'(acc_q) >= NUM_ACC;
  assign amt_ext = {{(BAL_W-AMT_W){1'b0}}, amt_q};
  assign sum     = {1'b0, rd} + {1'b0, amt_ext};

  always_comb begin
    err_c = ERR_OK;
    res   = rd;
    wr_en = 1'b0;
    unique case (1'b1)
      bad: begin
        err_c = ERR_BAD_ACC;
        res   = '0;
      end
      !bad && op_q == OP_BAL: begin
        err_c = ERR_OK;
      end
      !bad && op_q == OP_WD: begin
        if (amt_ext > rd) begin
          err_c = ERR_INSUF;
        end else begin
          res   = rd - amt_ext;
          wr_en = 1'b1;
        end
      end
      !bad && op_q == OP_DEP: begin
        if (sum[BAL_W]) begin
          err_c = ERR_OVF;
        end else begin
          res   = sum[BAL_W-1:0];
          wr_en = 1'b1;
        end
      end
      default: err_c = ERR_OVF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= PW'(NUM_REQ - 1);
      op_q         <= OP_BAL;
      acc_q        <= '0;
      amt_q        <= '0;
      resp_id      <= '0;
      resp_err     <= '0;
      resp_balance <= '0;
      for (int i = 0; i < NUM_ACC; i++) bal[i] <= INIT_BAL;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && |grant) begin
        rr_ptr <= gid;
        op_q   <= op_sel;
        acc_q  <= acc_sel;
        amt_q  <= amt_sel;
      end
      if (state == S_EXEC) begin
        resp_id      <= 3'(rr_ptr);
        resp_err     <= err_c;
        resp_balance <= res;
        for (int i = 0; i < NUM_ACC; i++) begin
          if (wr_en && acc_q == 4'(i)) bal[i] <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_account_arbiter.sv
// Bench for account_arbiter: directed cases plus random traffic
// checked cycle by cycle against a transaction-level model.
module tb_account_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [15:0] req_acc;
  logic [63:0] req_amt;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [2:0]  resp_id;
  logic [1:0]  resp_err;
  logic [31:0] resp_balance;
  logic        busy;

  logic        rv   [4];
  logic [1:0]  rop  [4];
  logic [3:0]  racc [4];
  logic [15:0] ramt [4];

  logic [1:0]  h_valid;
  logic [3:0]  h_op;
  logic [7:0]  h_acc;
  logic [31:0] h_amt;
  logic [1:0]  h_ready;
  logic        h_rv;
  logic [2:0]  h_id;
  logic [1:0]  h_err;
  logic [31:0] h_bal;
  logic        h_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i]          = rv[i];
      req_op[2*i +: 2]      = rop[i];
      req_acc[4*i +: 4]     = racc[i];
      req_amt[16*i +: 16]   = ramt[i];
    end
  end

  account_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_acc(req_acc), .req_amt(req_amt),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_err(resp_err),
    .resp_balance(resp_balance), .busy(busy)
  );

  account_arbiter #(
    .NUM_REQ(2), .INIT_BAL(32'hFFFF_F000)
  ) dut_hi (
    .clk(clk), .rst(rst),
    .req_valid(h_valid), .req_op(h_op),
    .req_acc(h_acc), .req_amt(h_amt),
    .req_ready(h_ready), .resp_valid(h_rv),
    .resp_id(h_id), .resp_err(h_err),
    .resp_balance(h_bal), .busy(h_busy)
  );

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // Transaction-level model: one outstanding transaction at a time
  longint m_bal [10];
  int     m_phase = 0;
  int     m_last  = 3;
  int     m_err;
  longint m_res;
  int     m_id;
  int     gq [$];

  task automatic model_exec(input int g);
    int     op, acc;
    longint amt, b;
    op  = int'(req_op[2*g +: 2]);
    acc = int'(req_acc[4*g +: 4]);
    amt = longint'(req_amt[16*g +: 16]);
    m_id = g;
    if (acc >= 10) begin
      m_err = 2; m_res = 0;
    end else begin
      b = m_bal[acc];
      m_err = 0; m_res = b;
      if (op == 3) m_err = 3;
      else if (op == 1) begin
        if (amt > b) m_err = 1;
        else m_res = b - amt;
      end else if (op == 2) begin
        if (b + amt > 64'hFFFF_FFFF) m_err = 3;
        else m_res = b + amt;
      end
      m_bal[acc] = m_res;
    end
  endtask

  always @(negedge clk) begin
    int g, idx;
    logic [3:0] er;
    g = -1;
    if (m_phase == 0) begin
      for (int i = 1; i <= 4; i++) begin
        idx = (m_last + i) % 4;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'd0;
    if (chk_en) begin
      chk("req_ready", req_ready, er);
      chk("busy", busy, m_phase != 0);
      chk("resp_valid", resp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_err", resp_err, m_err);
        chk("resp_balance", resp_balance, m_res);
      end
    end
    if (rst) begin
      m_phase = 0;
      m_last  = 3;
      for (int i = 0; i < 10; i++) m_bal[i] = 500;
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
          model_exec(g);
          gq.push_back(g);
          m_last  = g;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic txn(input int r, input logic [1:0] op,
                     input logic [3:0] acc, input logic [15:0] amt,
                     output logic [1:0] err, output logic [31:0] bal,
                     output int gc, output int rc);
    bit got;
    err = 0; bal = 0; gc = -1; rc = -1;
    @(posedge clk); #1;
    rv[r] = 1'b1; rop[r] = op; racc[r] = acc; ramt[r] = amt;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin got = 1; gc = cyc; end
    end
    chk("grant_seen", got, 1);
    @(posedge clk); #1;
    rv[r] = 1'b0;
    if (!got) return;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (resp_valid && resp_id == 3'(r)) begin
        got = 1; rc = cyc; err = resp_err; bal = resp_balance;
      end
    end
    chk("resp_seen", got, 1);
  endtask

  task automatic hi_txn(input logic [1:0] op, input logic [15:0] amt,
                        output logic [1:0] err, output logic [31:0] bal);
    bit got;
    err = 0; bal = 0;
    @(posedge clk); #1;
    h_valid = 2'b01; h_op = {2'b00, op}; h_acc = 8'h05;
    h_amt = {16'h0, amt};
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (h_ready[0]) got = 1;
    end
    chk("hi_grant_seen", got, 1);
    @(posedge clk); #1;
    h_valid = 2'b00;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (h_rv) begin got = 1; err = h_err; bal = h_bal; end
    end
    chk("hi_resp_seen", got, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0]  e;
  logic [31:0] b;
  int          gc, rc, cnt;
  logic [1:0]  fe [4];
  logic [31:0] fb [4];
  int          fg [4];
  int          fr [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      rv[i] = 0; rop[i] = 0; racc[i] = 0; ramt[i] = 0;
    end
    h_valid = 0; h_op = 0; h_acc = 0; h_amt = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_balance", resp_balance, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;

    txn(0, 2'd0, 4'd3, 16'd0, e, b, gc, rc);
    chk("bal3_latency", rc - gc, 2);
    chk("bal3_err", e, 0);
    chk("bal3_bal", b, 500);

    txn(1, 2'd1, 4'd2, 16'd200, e, b, gc, rc);
    chk("wd200_err", e, 0);
    chk("wd200_bal", b, 300);
    txn(2, 2'd1, 4'd2, 16'd400, e, b, gc, rc);
    chk("wd400_err", e, 1);
    chk("wd400_bal", b, 300);
    txn(3, 2'd1, 4'd2, 16'd300, e, b, gc, rc);
    chk("wd_exact_err", e, 0);
    chk("wd_exact_bal", b, 0);

    txn(0, 2'd2, 4'd5, 16'd100, e, b, gc, rc);
    chk("dep100_err", e, 0);
    chk("dep100_bal", b, 600);
    txn(1, 2'd0, 4'd5, 16'd0, e, b, gc, rc);
    chk("dep_readback", b, 600);

    txn(2, 2'd0, 4'd12, 16'd0, e, b, gc, rc);
    chk("badacc_err", e, 2);
    chk("badacc_bal", b, 0);
    txn(3, 2'd3, 4'd4, 16'd7, e, b, gc, rc);
    chk("badop_err", e, 3);
    chk("badop_bal", b, 500);

    hi_txn(2'd2, 16'hFFFF, e, b);
    chk("ovf_err", e, 3);
    chk("ovf_bal", b, 32'hFFFF_F000);
    hi_txn(2'd2, 16'h0FFF, e, b);
    chk("top_err", e, 0);
    chk("top_bal", b, 32'hFFFF_FFFF);
    hi_txn(2'd2, 16'd1, e, b);
    chk("ovf1_err", e, 3);
    hi_txn(2'd2, 16'd0, e, b);
    chk("dep0_err", e, 0);
    chk("dep0_bal", b, 32'hFFFF_FFFF);

    // Reset lands while a withdraw is executing
    @(posedge clk); #1;
    rv[0] = 1; rop[0] = 2'd1; racc[0] = 4'd0; ramt[0] = 16'd100;
    cnt = 0;
    for (int i = 0; i < 20 && !req_ready[0]; i++) @(negedge clk);
    chk("rstmid_grant", req_ready[0], 1);
    @(posedge clk); #1;
    rv[0] = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("rstmid_no_resp", cnt, 0);
    txn(0, 2'd0, 4'd0, 16'd0, e, b, gc, rc);
    chk("rstmid_bal", b, 500);

    do_reset();
    gq.delete();
    for (int i = 0; i < 4; i++) begin
      fork
        automatic int k = i;
        txn(k, 2'd2, 4'd1, 16'd10, fe[k], fb[k], fg[k], fr[k]);
      join_none
    end
    wait fork;
    chk("fair_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("fair_order", gq[i], i);
    for (int i = 0; i < 4; i++)
      chk("fair_bal", fb[i], 510 + 10 * i);
    for (int i = 1; i < 4; i++)
      chk("fair_spacing", fr[i] - fr[i-1], 3);

    for (int i = 0; i < 4; i++) begin
      fork
        automatic int k = i;
        begin
          logic [1:0]  re;
          logic [31:0] rb;
          int          rg, rr;
          logic [15:0] amt;
          repeat (25) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            amt = ($urandom_range(0, 3) == 0) ? 16'd0
                  : 16'($urandom_range(1, 400));
            txn(k, 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 11)), amt, re, rb, rg, rr);
          end
        end
      join_none
    end
    wait fork;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/account_arbiter.md
# account_arbiter

Shared-balance arbiter and sequencer that lets NUM_REQ ATM front-ends access one on-chip balance store. It accepts balance, withdraw and deposit transactions over per-requester valid/ready handshakes and grants one requester at a time, round-robin. Each granted transaction runs as an atomic read-modify-write on the balance array, then returns the result on a shared, tagged response bus. It sits between the ATM FSMs (after authentication) and the balance storage, which it owns.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting ATM front-ends (2..8).
- NUM_ACC, 10: number of accounts in the balance store.
- BAL_W, 32: balance width, unsigned.
- AMT_W, 16: transaction amount width, unsigned.
- INIT_BAL, 500: balance loaded into every account on reset.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op  in  2*NUM_REQ  packed op per requester: 0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 reserved.
- req_acc  in  4*NUM_REQ  packed account index per requester.
- req_amt  in  AMT_W*NUM_REQ  packed amount per requester; ignored for BALANCE.
- req_ready  out  NUM_REQ  one-hot grant pulse, one cycle.
- resp_valid  out  1  response strobe, one cycle.
- resp_id  out  3  index of the requester being answered.
- resp_err  out  2  0 OK, 1 INSUFFICIENT, 2 BAD_ACC, 3 BAD_OP_OR_OVERFLOW.
- resp_balance  out  BAL_W  account balance after the transaction; 0 on BAD_ACC.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the round-robin arbiter picks requester g, searching from rr_ptr+1 and wrapping.
  - req_ready[g] is driven high combinationally in this cycle.
  - At the clock edge: latch op, acc and amt of g; set rr_ptr to g; go to EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC:
  - Read bal[acc] and compute the result.
  - At the edge: write bal[acc] if needed, register the resp_* fields, go to RESP.
- RESP: resp_valid=1 for exactly this cycle; next state IDLE.
- Arithmetic (operands zero-extended to BAL_W):
  - acc >= NUM_ACC: err=BAD_ACC, no write, balance=0.
  - op 3: err=3, no write, balance=bal.
  - BALANCE: err=OK, no write, balance=bal.
  - WITHDRAW: if amt > bal, err=INSUFFICIENT, no write. Otherwise write bal-amt, err=OK. amt==bal is allowed and gives 0.
  - DEPOSIT: if bal+amt overflows BAL_W bits (carry out), err=3, no write. Otherwise write bal+amt, err=OK.
  - amt=0 is legal for all ops and leaves the balance unchanged.
- Requester rules:
  - Hold req_valid and payload stable until it sees req_ready.
  - May drop req_valid after the grant and wait for resp_valid with a matching resp_id.
  - Must not re-request before that response arrives.
- Same account from two requesters: serialized. The later transaction sees the earlier write.

## Timing
- Reset values: state IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), req_ready=0, resp_valid=0, resp_id=0, resp_err=0, resp_balance=0, busy=0, all bal[i]=INIT_BAL.
- Reset mid-transaction: the in-flight transaction is dropped, no response is issued, and all balances reload.
- Latency: grant in cycle T → write takes effect at the end of T+1 → resp_valid in T+2 → next grant possible in T+3. Throughput is one transaction per 3 cycles.
- req_ready is asserted only in IDLE and is never high for more than one requester.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,NUM_REQ-1,0. Any requester waits at most NUM_REQ-1 transactions.
- A requester asserting valid in the same cycle as another's response is arbitrated in the following IDLE cycle.

## Structure
- Shared definitions file holds:
  - op codes (BALANCE/WITHDRAW/DEPOSIT);
  - resp_err codes;
  - FSM state encodings (IDLE/EXEC/RESP);
  - INIT_BAL default.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], ptr, en;
  - output grant[N], one-hot, combinational;
  - the pointer register lives in account_arbiter.
- The balance array is a register array inside account_arbiter (single read and single write port per cycle).

## Test plan
- Reset, then requester 0 sends BALANCE acc 3 → req_ready[0] in cycle T, resp_valid in T+2, id=0, err=0, balance=500.
- WITHDRAW acc 2 amt 200 then WITHDRAW acc 2 amt 400 → first gives err=0, balance=300; second gives err=1, balance=300 unchanged.
- DEPOSIT acc 5 amt 65535 when bal=0xFFFFF000 → err=3, balance unchanged. DEPOSIT acc 5 amt 100 from reset → balance=600.
- All 4 requesters hold valid with DEPOSIT acc 1 amt 10 → grant order 0,1,2,3, responses 3 cycles apart, final balances 510, 520, 530, 540.
- BALANCE acc 12 → err=2, balance=0. rst asserted during EXEC of WITHDRAW acc 0 amt 100 → no resp_valid; a following BALANCE acc 0 returns 500.
